// File: rtl/rssi_pkg.sv
// Shared sizing helpers and default geometry for the RSSI energy scanner.
package rssi_pkg;
  localparam int DEF_DATA_W  = 10;
  localparam int DEF_WIN_LEN = 105;
  localparam int DEF_NUM_CH  = 4;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Worst case: WIN_LEN full-scale squares, so the window sum cannot wrap.
  function automatic int acc_w(input int data_w, input int win_len);
    return 2 * data_w + clog2(win_len);
  endfunction
endpackage

// File: rtl/rssi_square.sv
// Registered squarer stage: squares the tagged sample and filters out-of-range channel tags.
module rssi_square import rssi_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SIGNED = 0,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_clr,
  input  logic                i_valid,
  input  logic [CH_W-1:0]     i_ch,
  input  logic [DATA_W-1:0]   i_x,
  output logic                o_valid,
  output logic [CH_W-1:0]     o_ch,
  output logic [2*DATA_W-1:0] o_sq
);
  logic                w_fill;
  logic [2*DATA_W-1:0] w_ext;
  logic [2*DATA_W-1:0] w_sq;
  logic                w_ch_ok;

  // Low 2*DATA_W bits of the product are exact for both sign- and zero-extension.
  assign w_fill  = (SIGNED != 0) && i_x[DATA_W-1];
  assign w_ext   = {{DATA_W{w_fill}}, i_x};
  assign w_sq    = w_ext * w_ext;
  assign w_ch_ok = {1'b0, i_ch} < (CH_W+1)'(NUM_CH);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_sq    <= '0;
    end else begin
      o_valid <= i_valid && w_ch_ok && !i_clr;
      o_ch    <= i_ch;
      o_sq    <= w_sq;
    end
  end
endmodule

// File: rtl/rssi_energy_scanner.sv
// Per-channel windowed energy accumulator with threshold flag and per-scan peak tracker.
module rssi_energy_scanner import rssi_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SIGNED  = 0,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CH_W    = 2,
  localparam int ACC_W  = acc_w(DATA_W, WIN_LEN)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_x,
  input  logic [ACC_W-1:0]  thresh,
  input  logic              scan_start,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [ACC_W-1:0]  res_sum,
  output logic              res_above,
  output logic              peak_valid,
  output logic [CH_W-1:0]   peak_ch,
  output logic [ACC_W-1:0]  peak_sum
);
  localparam int CNT_W = (clog2(WIN_LEN) < 1) ? 1 : clog2(WIN_LEN);

  logic                            w_vld;
  logic [CH_W-1:0]                 w_ch;
  logic [2*DATA_W-1:0]             w_sq;
  logic [NUM_CH-1:0][ACC_W-1:0]    r_acc;
  logic [NUM_CH-1:0][CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]                w_acc_sel;
  logic [CNT_W-1:0]                w_cnt_sel;
  logic [ACC_W-1:0]                w_sum;
  logic                            w_last;
  logic                            r_res_valid;
  logic [CH_W-1:0]                 r_res_ch;
  logic [ACC_W-1:0]                r_res_sum;
  logic                            r_res_above;
  logic                            r_peak_valid;
  logic [CH_W-1:0]                 r_peak_ch;
  logic [ACC_W-1:0]                r_peak_sum;

  rssi_square #(
    .DATA_W (DATA_W),
    .SIGNED (SIGNED),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_sq (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (clr),
    .i_valid (in_valid),
    .i_ch    (in_ch),
    .i_x     (in_x),
    .o_valid (w_vld),
    .o_ch    (w_ch),
    .o_sq    (w_sq)
  );

  always_comb begin
    w_acc_sel = '0;
    w_cnt_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == CH_W'(c)) begin
        w_acc_sel = r_acc[c];
        w_cnt_sel = r_cnt[c];
      end
    end
  end

  assign w_sum  = w_acc_sel + ACC_W'(w_sq);
  assign w_last = (w_cnt_sel == CNT_W'(WIN_LEN - 1));

  // Read-modify-write in one cycle, so same-channel back-to-back samples need no forwarding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_vld) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_ch == CH_W'(c)) begin
          r_acc[c] <= w_last ? '0 : w_sum;
          r_cnt[c] <= w_last ? '0 : r_cnt[c] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_res_sum   <= '0;
      r_res_above <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (!clr && w_vld && w_last) begin
        r_res_valid <= 1'b1;
        r_res_ch    <= w_ch;
        r_res_sum   <= w_sum;
        r_res_above <= (w_sum >= thresh);
      end
    end
  end

  // A result coinciding with scan_start seeds the new scan instead of being lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_peak_valid <= 1'b0;
      r_peak_ch    <= '0;
      r_peak_sum   <= '0;
    end else if (scan_start) begin
      r_peak_valid <= r_res_valid;
      r_peak_ch    <= r_res_valid ? r_res_ch  : '0;
      r_peak_sum   <= r_res_valid ? r_res_sum : '0;
    end else if (r_res_valid && (!r_peak_valid || r_res_sum > r_peak_sum)) begin
      r_peak_valid <= 1'b1;
      r_peak_ch    <= r_res_ch;
      r_peak_sum   <= r_res_sum;
    end
  end

  assign res_valid  = r_res_valid;
  assign res_ch     = r_res_ch;
  assign res_sum    = r_res_sum;
  assign res_above  = r_res_above;
  assign peak_valid = r_peak_valid;
  assign peak_ch    = r_peak_ch;
  assign peak_sum   = r_peak_sum;
endmodule

// File: tb/tb_rssi_energy_scanner.sv
// Bench: unsigned and signed scanners on shared inputs, checked against an arithmetic window model.
module tb_rssi_energy_scanner;
  localparam int DW  = 10;
  localparam int WIN = 105;
  localparam int NCH = 4;
  localparam int CW  = 3;
  localparam int AW  = 27;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ch = '0;
  logic [DW-1:0] in_x = '0;
  logic [AW-1:0] thresh = '0;
  logic          scan_start = 1'b0;

  logic          u_rv, s_rv, u_ra, s_ra, u_pv, s_pv;
  logic [CW-1:0] u_rc, s_rc, u_pc, s_pc;
  logic [AW-1:0] u_rs, s_rs, u_ps, s_ps;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rssi_energy_scanner #(.DATA_W(DW), .SIGNED(0), .WIN_LEN(WIN), .NUM_CH(NCH), .CH_W(CW)) u_dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ch(in_ch), .in_x(in_x),
    .thresh(thresh), .scan_start(scan_start), .res_valid(u_rv), .res_ch(u_rc), .res_sum(u_rs),
    .res_above(u_ra), .peak_valid(u_pv), .peak_ch(u_pc), .peak_sum(u_ps));

  rssi_energy_scanner #(.DATA_W(DW), .SIGNED(1), .WIN_LEN(WIN), .NUM_CH(NCH), .CH_W(CW)) u_dut_s (
    .clk(clk), .rstn(rstn), .clr(clr), .in_valid(in_valid), .in_ch(in_ch), .in_x(in_x),
    .thresh(thresh), .scan_start(scan_start), .res_valid(s_rv), .res_ch(s_rc), .res_sum(s_rs),
    .res_above(s_ra), .peak_valid(s_pv), .peak_ch(s_pc), .peak_sum(s_ps));

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: per-channel sample count and square sums; a window that fills is visible one edge later.
  int     m_cnt [NCH];
  longint m_su  [NCH];
  longint m_ss  [NCH];
  bit     pend_v;
  int     pend_ch;
  longint pend_su, pend_ss;
  bit     e_rv, e_au, e_as;
  int     e_ch;
  longint e_su, e_ss;
  bit     pv_u, pv_s;
  int     pc_u, pc_s;
  longint ps_u, ps_s;
  longint xu, xs;
  int     mc;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; m_su[c] = 0; m_ss[c] = 0; end
      pend_v = 0; e_rv = 0; e_ch = 0; e_su = 0; e_ss = 0; e_au = 0; e_as = 0;
      pv_u = 0; pc_u = 0; ps_u = 0; pv_s = 0; pc_s = 0; ps_s = 0;
    end else begin
      if (scan_start) begin
        pv_u = e_rv; pc_u = e_rv ? e_ch : 0; ps_u = e_rv ? e_su : 0;
        pv_s = e_rv; pc_s = e_rv ? e_ch : 0; ps_s = e_rv ? e_ss : 0;
      end else if (e_rv) begin
        if (!pv_u || e_su > ps_u) begin pv_u = 1; pc_u = e_ch; ps_u = e_su; end
        if (!pv_s || e_ss > ps_s) begin pv_s = 1; pc_s = e_ch; ps_s = e_ss; end
      end
      e_rv = 0;
      if (pend_v && !clr) begin
        e_rv = 1; e_ch = pend_ch; e_su = pend_su; e_ss = pend_ss;
        e_au = (pend_su >= longint'(thresh));
        e_as = (pend_ss >= longint'(thresh));
      end
      pend_v = 0;
      if (clr) begin
        for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; m_su[c] = 0; m_ss[c] = 0; end
      end else if (in_valid && in_ch < NCH) begin
        mc = int'(in_ch);
        xu = longint'(in_x);
        xs = longint'($signed(in_x));
        m_cnt[mc]++;
        m_su[mc] += xu * xu;
        m_ss[mc] += xs * xs;
        if (m_cnt[mc] == WIN) begin
          pend_v = 1; pend_ch = mc; pend_su = m_su[mc]; pend_ss = m_ss[mc];
          m_cnt[mc] = 0; m_su[mc] = 0; m_ss[mc] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("u_res_valid", u_rv, e_rv);
    chk("s_res_valid", s_rv, e_rv);
    chk("u_res_ch", u_rc, e_ch);
    chk("s_res_ch", s_rc, e_ch);
    chk("u_res_sum", u_rs, e_su);
    chk("s_res_sum", s_rs, e_ss);
    chk("u_res_above", u_ra, e_au);
    chk("s_res_above", s_ra, e_as);
    chk("u_peak_valid", u_pv, pv_u);
    chk("s_peak_valid", s_pv, pv_s);
    chk("u_peak_ch", u_pc, pc_u);
    chk("s_peak_ch", s_pc, pc_s);
    chk("u_peak_sum", u_ps, ps_u);
    chk("s_peak_sum", s_ps, ps_s);
  end

  task automatic drv(input bit v, input int ch, input int x, input bit c, input bit ss);
    @(posedge clk);
    #1;
    in_valid   = v;
    in_ch      = CW'(ch);
    in_x       = DW'(x);
    clr        = c;
    scan_start = ss;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0);
  endtask

  initial begin
    #1 rstn = 1'b0;
    #20;
    chk("rst_res_valid", u_rv, 0);
    chk("rst_res_sum", u_rs, 0);
    chk("rst_peak_valid", u_pv, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // Single channel full-scale-ish window
    drv(0, 0, 0, 0, 1);
    for (int i = 0; i < WIN; i++) drv(1, 0, 1000, 0, 0);
    drv(0, 0, 0, 0, 0);
    chk("t1_no_early", u_rv, 0);
    drv(0, 0, 0, 0, 0);
    chk("t1_pulse", u_rv, 1);
    chk("t1_sum", u_rs, 105000000);
    chk("t1_ch", u_rc, 0);
    idle(2);
    chk("t1_hold", u_rs, 105000000);

    // Round robin, fresh scan
    drv(0, 0, 0, 0, 1);
    for (int i = 0; i < WIN; i++)
      for (int c = 0; c < NCH; c++) drv(1, c, c + 1, 0, 0);
    idle(3);
    chk("rr_last_sum", u_rs, 1680);
    chk("rr_peak_ch", u_pc, 3);
    chk("rr_peak_sum", u_ps, 1680);

    // Signed -512 on ch2 with threshold right at the sum, then one above
    thresh = 27'd27525120;
    for (int i = 0; i < WIN; i++) drv(1, 2, 10'h200, 0, 0);
    idle(2);
    chk("sg_sum", s_rs, 27525120);
    chk("sg_above_eq", s_ra, 1);
    thresh = 27'd27525121;
    for (int i = 0; i < WIN; i++) drv(1, 2, 10'h200, 0, 0);
    idle(2);
    chk("sg_above_gt", s_ra, 0);
    // -1 differs between signed and unsigned views
    for (int i = 0; i < WIN; i++) drv(1, 2, 10'h3FF, 0, 0);
    idle(2);
    chk("sg_m1_s", s_rs, 105);
    chk("sg_m1_u", u_rs, 105 * 1023 * 1023);

    // Partial window discarded by clr; out-of-range tag ignored
    for (int i = 0; i < 50; i++) drv(1, 1, 9, 0, 0);
    drv(1, 1, 9, 1, 0);
    for (int i = 0; i < WIN; i++) begin
      drv(1, 1, 2, 0, 0);
      drv(1, 5, 1000, 0, 0);
    end
    idle(2);
    chk("clr_sum", u_rs, 420);
    chk("clr_ch", u_rc, 1);

    // Equal sums: earlier channel wins
    drv(0, 0, 0, 0, 1);
    for (int i = 0; i < WIN; i++) begin
      drv(1, 1, 3, 0, 0);
      drv(1, 3, 3, 0, 0);
    end
    idle(3);
    chk("tie_peak_ch", u_pc, 1);
    chk("tie_peak_sum", u_ps, 945);

    // scan_start on the result cycle: that result seeds the new scan
    for (int i = 0; i < WIN; i++) drv(1, 2, 1, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1);
    chk("ss_rv_seen", u_rv, 1);
    idle(1);
    chk("ss_peak_valid", u_pv, 1);
    chk("ss_peak_ch", u_pc, 2);
    chk("ss_peak_sum", u_ps, 105);

    // Reset mid-window, then a complete window
    for (int i = 0; i < 50; i++) drv(1, 0, 5, 0, 0);
    @(posedge clk); #1 rstn = 1'b0; in_valid = 1'b0;
    #2;
    chk("mr_res_sum", u_rs, 0);
    chk("mr_res_ch", u_rc, 0);
    chk("mr_peak_sum", u_ps, 0);
    chk("mr_peak_valid", u_pv, 0);
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < WIN; i++) drv(1, 0, 5, 0, 0);
    idle(2);
    chk("mr_full_sum", u_rs, 2625);

    // Randomized traffic
    for (int i = 0; i < 8000; i++) begin
      thresh = AW'($urandom_range(0, 60000000));
      drv($urandom_range(0, 9) < 8, $urandom_range(0, 4), $urandom_range(0, 1023),
          $urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
